// File: rtl/carryless_multiply_unit_if.sv
// Request/response bundle for the carry-less multiplier.
// The _i/_o suffixes are named from the unit's point of view.
interface carryless_multiply_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] operand_A_i;
  logic [DATA_WIDTH-1:0] operand_B_i;
  logic [1:0]            operation_i;
  logic                  data_valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  data_valid_o;

  modport master (
    output operand_A_i, operand_B_i, operation_i, data_valid_i,
    input  ready_o, result_o, data_valid_o
  );

  modport slave (
    input  operand_A_i, operand_B_i, operation_i, data_valid_i,
    output ready_o, result_o, data_valid_o
  );
endinterface

// File: rtl/carryless_multiply_unit.sv
// Iterative carry-less multiplier (CLMUL / CLMULH / CLMULR).
// Consumes BITS_PER_CYCLE bits of B per COMPUTE cycle. A is kept pre-shifted
// and B is shifted down each cycle, so only the low bits of B are examined.
// The result register is loaded on the edge that enters DONE.
module carryless_multiply_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         clk_en_i,
  input  logic                         flush_i,
  carryless_multiply_unit_if.slave     bus
);

  localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [PW-1:0]         a_sh_q, a_sh_d;
  logic [DATA_WIDTH-1:0] b_sh_q, b_sh_d;
  logic [1:0]            op_q, op_d;
  logic [PW-1:0]         partial;

  // Pick the result window out of the full double-width product.
  function automatic logic [DATA_WIDTH-1:0] select_result(input logic [PW-1:0] p,
                                                          input logic [1:0]    op);
    case (op)
      2'd0:    select_result = p[DATA_WIDTH-1:0];
      2'd1:    select_result = p[PW-1:DATA_WIDTH];
      2'd2:    select_result = p[PW-2:DATA_WIDTH-1];
      default: select_result = '0;
    endcase
  endfunction

  // XOR of the shifted multiplicand for every set bit in the current B slice.
  always_comb begin
    partial = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (b_sh_q[k]) partial = partial ^ (a_sh_q << k);
    end
  end

  // Next-state and datapath update; flush overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    res_d   = res_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.data_valid_i) begin
          state_d = COMPUTE;
          a_sh_d  = {{DATA_WIDTH{1'b0}}, bus.operand_A_i};
          b_sh_d  = bus.operand_B_i;
          op_d    = bus.operation_i;
          prod_d  = '0;
          cnt_d   = '0;
        end
      end
      COMPUTE: begin
        prod_d = prod_q ^ partial;
        a_sh_d = a_sh_q << BITS_PER_CYCLE;
        b_sh_d = b_sh_q >> BITS_PER_CYCLE;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = select_result(prod_q ^ partial, op_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  // Control state, product and result: async reset, frozen while clk_en_i is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
    end
  end

  // Latched operands and opcode; only meaningful while COMPUTE, so no reset.
  always_ff @(posedge clk_i) begin
    if (clk_en_i) begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      op_q   <= op_d;
    end
  end

  assign bus.ready_o      = (state_q == IDLE);
  assign bus.data_valid_o = (state_q == DONE) & ~flush_i;
  assign bus.result_o     = res_q;

endmodule

// File: tb/tb_carryless_multiply_unit.sv
// Randomised and directed bench for carryless_multiply_unit (W=32, 4 bits/cycle).
module tb_carryless_multiply_unit;

  localparam int W = 32;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic flush;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] last_res;

  carryless_multiply_unit_if #(.DATA_WIDTH(W)) bus ();

  carryless_multiply_unit #(.DATA_WIDTH(W), .BITS_PER_CYCLE(4)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .clk_en_i (clk_en),
    .flush_i  (flush),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less product straight from the definition: XOR of A<<i for each set B[i].
  function automatic logic [W-1:0] ref_clmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    logic [2*W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
    end
    case (op)
      2'd0:    ref_clmul = p[W-1:0];
      2'd1:    ref_clmul = p[2*W-1:W];
      2'd2:    ref_clmul = p[2*W-2:W-1];
      default: ref_clmul = '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    bus.operand_A_i  = a;
    bus.operand_B_i  = b;
    bus.operation_i  = op;
    bus.data_valid_i = 1'b1;
    tick();
    bus.data_valid_i = 1'b0;
  endtask

  // One complete operation. req_at: edge index with a stray request (0 = none).
  // stall_at/stall_len: edges on which clk_en is low.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input int req_at, input int stall_at, input int stall_len);
    logic [W-1:0] exp;
    int last;
    exp  = ref_clmul(a, b, op);
    last = N + stall_len;
    start(a, b, op);
    chk("busy_after_accept", bus.ready_o, 1'b0);
    for (int j = 1; j <= last; j++) begin
      clk_en = !(stall_len > 0 && j >= stall_at && j < stall_at + stall_len);
      if (j == req_at) begin
        bus.data_valid_i = 1'b1;
        bus.operand_A_i  = $urandom;
        bus.operand_B_i  = $urandom;
        bus.operation_i  = 2'($urandom_range(0, 3));
      end else begin
        bus.data_valid_i = 1'b0;
      end
      tick();
      chk("valid_timing", bus.data_valid_o, (j == last));
      chk("ready_busy", bus.ready_o, 1'b0);
    end
    clk_en = 1'b1;
    bus.data_valid_i = 1'b0;
    chk("result", bus.result_o, exp);
    last_res = exp;
    tick();
    chk("ready_after", bus.ready_o, 1'b1);
    chk("valid_after", bus.data_valid_o, 1'b0);
    chk("result_hold", bus.result_o, exp);
  endtask

  initial begin
    logic [W-1:0] a, b, exp;
    logic [1:0] op;

    rst_n = 1'b0;
    clk_en = 1'b1;
    flush = 1'b0;
    bus.operand_A_i = '0;
    bus.operand_B_i = '0;
    bus.operation_i = '0;
    bus.data_valid_i = 1'b0;
    last_res = '0;
    tick();
    tick();
    chk("rst_ready", bus.ready_o, 1'b1);
    chk("rst_valid", bus.data_valid_o, 1'b0);
    chk("rst_result", bus.result_o, '0);
    rst_n = 1'b1;
    tick();

    // Directed values
    run_op(32'h00000003, 32'h00000003, 2'd0, 0, 0, 0);
    run_op(32'h80000000, 32'h80000000, 2'd1, 0, 0, 0);
    run_op(32'h80000000, 32'h80000000, 2'd2, 0, 0, 0);
    run_op(32'h80000000, 32'h80000000, 2'd0, 0, 0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 0, 0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd1, 0, 0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 0, 0, 0);

    // Stray request while busy, then back-to-back request right after
    run_op(32'h12345678, 32'h9ABCDEF0, 2'd2, 3, 0, 0);
    run_op(32'hDEADBEEF, 32'h0F0F0F0F, 2'd1, 0, 0, 0);

    // Stall during COMPUTE
    run_op(32'hCAFEF00D, 32'h13572468, 2'd0, 0, 3, 3);

    // Stall while in DONE keeps the pulse up
    a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; op = 2'd1;
    exp = ref_clmul(a, b, op);
    start(a, b, op);
    repeat (N) tick();
    chk("done_valid", bus.data_valid_o, 1'b1);
    clk_en = 1'b0;
    tick();
    chk("frozen_valid", bus.data_valid_o, 1'b1);
    chk("frozen_result", bus.result_o, exp);
    tick();
    chk("frozen_valid2", bus.data_valid_o, 1'b1);
    clk_en = 1'b1;
    tick();
    chk("unfrozen_valid", bus.data_valid_o, 1'b0);
    chk("unfrozen_ready", bus.ready_o, 1'b1);
    last_res = exp;

    // Flush mid-compute: back to IDLE, no pulse, result unchanged
    start(32'h11111111, 32'h22222222, 2'd0);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", bus.ready_o, 1'b1);
    chk("flush_valid", bus.data_valid_o, 1'b0);
    chk("flush_result", bus.result_o, last_res);
    run_op(32'h00000003, 32'h00000003, 2'd0, 0, 0, 0);

    // Flush while in DONE suppresses the pulse
    start(32'h0000FFFF, 32'h00FF00FF, 2'd0);
    repeat (N) tick();
    chk("pre_flush_valid", bus.data_valid_o, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_done_valid", bus.data_valid_o, 1'b0);
    tick();
    flush = 1'b0;
    chk("flush_done_ready", bus.ready_o, 1'b1);
    chk("flush_done_valid2", bus.data_valid_o, 1'b0);

    // Flush wins over a request in the same cycle
    bus.data_valid_i = 1'b1;
    flush = 1'b1;
    tick();
    bus.data_valid_i = 1'b0;
    flush = 1'b0;
    chk("flush_req_ready", bus.ready_o, 1'b1);
    tick();
    chk("flush_req_ready2", bus.ready_o, 1'b1);

    // Asynchronous reset in the middle of an operation
    start(32'h76543210, 32'hFEDCBA98, 2'd1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_ready", bus.ready_o, 1'b1);
    chk("arst_valid", bus.data_valid_o, 1'b0);
    chk("arst_result", bus.result_o, '0);
    tick();
    rst_n = 1'b1;
    tick();
    repeat (N) begin
      tick();
      chk("arst_no_pulse", bus.data_valid_o, 1'b0);
    end
    run_op(32'h76543210, 32'hFEDCBA98, 2'd1, 0, 0, 0);

    // Random operations
    for (int r = 0; r < 20; r++) begin
      run_op($urandom, $urandom, 2'($urandom_range(0, 3)),
             ((r % 4) == 1) ? int'($urandom_range(1, N)) : 0,
             ((r % 5) == 2) ? int'($urandom_range(1, 4)) : 0,
             ((r % 5) == 2) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
